// File: rtl/simple_seq_ctrl_if.sv
// Handshake and datapath bundle for simple_seq_ctrl.
// The pause signal exists only when SIMPLE_SEQ_PAUSE_EN is defined.
interface simple_seq_ctrl_if #(
    parameter int W     = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] iters;
    logic             abort;
    logic             clear;
`ifdef SIMPLE_SEQ_PAUSE_EN
    logic             pause;
`endif
    logic             busy;
    logic             done;
    logic [1:0]       phase;
    logic [CNT_W-1:0] remaining;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             c_q;

`ifdef SIMPLE_SEQ_PAUSE_EN
    modport master (
        output start, iters, abort, clear, pause,
        input  busy, done, phase, remaining, a_q, b_q, c_q
    );
    modport slave (
        input  start, iters, abort, clear, pause,
        output busy, done, phase, remaining, a_q, b_q, c_q
    );
`else
    modport master (
        output start, iters, abort, clear,
        input  busy, done, phase, remaining, a_q, b_q, c_q
    );
    modport slave (
        input  start, iters, abort, clear,
        output busy, done, phase, remaining, a_q, b_q, c_q
    );
`endif
endinterface

// File: rtl/simple_seq_ctrl.sv
// Bounded INC/INV/RED sequencer owning the A/B/C demo registers.
// Optional feature macro: SIMPLE_SEQ_PAUSE_EN (adds a pause input that stalls a run).
module simple_seq_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    simple_seq_ctrl_if.slave  bus
);
    localparam int H = W / 2;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INC  = 3'd1,
        S_INV  = 3'd2,
        S_RED  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     w_a_next;
    logic [W-1:0]     r_b;
    logic [W-1:0]     w_b_next;
    logic             r_c;
    logic             w_c_next;
    logic             w_stall;
    logic             w_busy;
    logic             w_done;
    logic [1:0]       w_phase;

`ifdef SIMPLE_SEQ_PAUSE_EN
    assign w_stall = bus.pause;
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_a         <= w_a_next;
            r_b         <= w_b_next;
            r_c         <= w_c_next;
        end
    end

    // Abort is tested before stall and before the phase write, so an aborted
    // phase never commits and a paused run can still be abandoned.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_a_next         = r_a;
        w_b_next         = r_b;
        w_c_next         = r_c;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.iters == '0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_remaining_next = bus.iters;
                        w_state_next     = S_INC;
                    end
                end else if (bus.clear) begin
                    w_a_next = '0;
                    w_b_next = '0;
                    w_c_next = 1'b0;
                end
            end
            S_INC: begin
                if (bus.abort) begin
                    w_remaining_next = '0;
                    w_state_next     = S_IDLE;
                end else if (!w_stall) begin
                    w_a_next     = r_a + 1'b1;
                    w_state_next = S_INV;
                end
            end
            S_INV: begin
                if (bus.abort) begin
                    w_remaining_next = '0;
                    w_state_next     = S_IDLE;
                end else if (!w_stall) begin
                    w_b_next[W-1:H] = ~r_a[H-1:0];
                    w_state_next    = S_RED;
                end
            end
            S_RED: begin
                if (bus.abort) begin
                    w_remaining_next = '0;
                    w_state_next     = S_IDLE;
                end else if (!w_stall) begin
                    w_c_next = &r_a[1:0];
                    if (r_remaining > CNT_ONE) begin
                        w_remaining_next = r_remaining - CNT_ONE;
                        w_state_next     = S_INC;
                    end else begin
                        w_remaining_next = '0;
                        w_state_next     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_phase = 2'd0;
        case (r_state)
            S_INC:   begin w_busy = 1'b1; w_phase = 2'd1; end
            S_INV:   begin w_busy = 1'b1; w_phase = 2'd2; end
            S_RED:   begin w_busy = 1'b1; w_phase = 2'd3; end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.phase     = w_phase;
    assign bus.remaining = r_remaining;
    assign bus.a_q       = r_a;
    assign bus.b_q       = r_b;
    assign bus.c_q       = r_c;

endmodule
